// File: rtl/gshare_predictor_param.sv
// Parameterised gshare direction predictor: speculative global history with mispredict recovery,
// sequential PHT init sweep. Optional macros: PERF_CNT_EN (perf counters), LOOKUP_BYPASS_EN.
module gshare_predictor_param #(
    parameter int INDEX_BITS = 8,
    parameter int GHR_BITS   = 8,
    parameter int CTR_BITS   = 2,
    parameter int CTR_INIT   = 2**(CTR_BITS-1)-1,
    parameter int PERF_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ready,
    input  logic [31:0]          pc,
    input  logic                 predict_req,
    output logic                 prediction,
    output logic                 prediction_valid,
    output logic [GHR_BITS-1:0]  pred_ghr,
    input  logic                 update_valid,
    input  logic [31:0]          update_pc,
    input  logic [GHR_BITS-1:0]  update_ghr,
    input  logic                 update_taken,
    input  logic                 update_correct,
    output logic [PERF_BITS-1:0] perf_lookups,
    output logic [PERF_BITS-1:0] perf_mispredicts
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(CTR_INIT);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state_reg, state_next;
    logic [INDEX_BITS-1:0] init_ptr_reg;
    logic                  ready_reg;
    logic [GHR_BITS-1:0]   spec_ghr_reg, spec_ghr_next;
    logic                  prediction_reg, prediction_valid_reg;
    logic [GHR_BITS-1:0]   pred_ghr_reg;

    logic [CTR_BITS-1:0]   pht [ENTRIES];

    logic                  running, lookup_en, update_en, recover_en;
    logic [INDEX_BITS-1:0] lookup_idx, update_idx;
    logic [CTR_BITS-1:0]   lookup_ctr, update_ctr, ctr_new;
    logic                  lookup_taken;
    logic [GHR_BITS-1:0]   lookup_shift, recover_val;
    logic                  pht_we;
    logic [INDEX_BITS-1:0] pht_waddr;
    logic [CTR_BITS-1:0]   pht_wdata;

    always_comb begin
        running    = (state_reg == ST_RUN);
        lookup_en  = running && predict_req;
        update_en  = running && update_valid;
        recover_en = update_en && !update_correct;
        lookup_idx = pc[INDEX_BITS+1:2] ^ INDEX_BITS'(spec_ghr_reg);
        update_idx = update_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(update_ghr);

        update_ctr = pht[update_idx];
        ctr_new    = update_ctr;
        if (update_taken) begin
            if (update_ctr != CTR_MAX)
                ctr_new = update_ctr + CTR_ONE;
        end else begin
            if (update_ctr != '0)
                ctr_new = update_ctr - CTR_ONE;
        end

        lookup_ctr = pht[lookup_idx];
`ifdef LOOKUP_BYPASS_EN
        if (update_en && (update_idx == lookup_idx))
            lookup_ctr = ctr_new;
`endif
        lookup_taken = lookup_ctr[CTR_BITS-1];
    end

    // A one-bit history has no older bits to keep, so it is simply replaced.
    generate
        if (GHR_BITS == 1) begin : g_ghr_one
            assign lookup_shift = lookup_taken;
            assign recover_val  = update_taken;
        end else begin : g_ghr_multi
            assign lookup_shift = {spec_ghr_reg[GHR_BITS-2:0], lookup_taken};
            assign recover_val  = {update_ghr[GHR_BITS-2:0], update_taken};
        end
    endgenerate

    always_comb begin
        spec_ghr_next = spec_ghr_reg;
        if (recover_en)
            spec_ghr_next = recover_val;
        else if (lookup_en)
            spec_ghr_next = lookup_shift;
    end

    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_INIT && (&init_ptr_reg))
            state_next = ST_RUN;
    end

    // The sweep owns the single write port until RUN; afterwards only updates write.
    always_comb begin
        pht_we    = 1'b0;
        pht_waddr = update_idx;
        pht_wdata = ctr_new;
        if (state_reg == ST_INIT) begin
            pht_we    = 1'b1;
            pht_waddr = init_ptr_reg;
            pht_wdata = CTR_RST;
        end else if (update_en) begin
            pht_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (pht_we)
            pht[pht_waddr] <= pht_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg            <= ST_INIT;
            init_ptr_reg         <= '0;
            ready_reg            <= 1'b0;
            spec_ghr_reg         <= '0;
            prediction_reg       <= 1'b0;
            prediction_valid_reg <= 1'b0;
            pred_ghr_reg         <= '0;
        end else begin
            state_reg            <= state_next;
            ready_reg            <= (state_next == ST_RUN);
            spec_ghr_reg         <= spec_ghr_next;
            prediction_valid_reg <= lookup_en;
            if (state_reg == ST_INIT)
                init_ptr_reg <= init_ptr_reg + 1'b1;
            if (lookup_en) begin
                prediction_reg <= lookup_taken;
                pred_ghr_reg   <= spec_ghr_reg;
            end
        end
    end

    assign ready            = ready_reg;
    assign prediction       = prediction_reg;
    assign prediction_valid = prediction_valid_reg;
    assign pred_ghr         = pred_ghr_reg;

`ifdef PERF_CNT_EN
    logic [PERF_BITS-1:0] perf_lookups_reg, perf_mispredicts_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lookups_reg     <= '0;
            perf_mispredicts_reg <= '0;
        end else begin
            if (lookup_en && !(&perf_lookups_reg))
                perf_lookups_reg <= perf_lookups_reg + 1'b1;
            if (recover_en && !(&perf_mispredicts_reg))
                perf_mispredicts_reg <= perf_mispredicts_reg + 1'b1;
        end
    end

    assign perf_lookups     = perf_lookups_reg;
    assign perf_mispredicts = perf_mispredicts_reg;
`else
    assign perf_lookups     = '0;
    assign perf_mispredicts = '0;
`endif

    // Only the index field of each PC participates in hashing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc[31:INDEX_BITS+2], pc[1:0],
                              update_pc[31:INDEX_BITS+2], update_pc[1:0]};

endmodule

// File: tb/tb_gshare_predictor_param.sv
// Directed bench for gshare_predictor_param (INDEX_BITS=8, GHR_BITS=8, CTR_BITS=2).
module tb_gshare_predictor_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [31:0] pc;
    logic        predict_req;
    logic        prediction;
    logic        prediction_valid;
    logic [7:0]  pred_ghr;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [7:0]  update_ghr;
    logic        update_taken;
    logic        update_correct;
    logic [31:0] perf_lookups;
    logic [31:0] perf_mispredicts;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gshare_predictor_param #(
        .INDEX_BITS(8), .GHR_BITS(8), .CTR_BITS(2), .PERF_BITS(32)
    ) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .pc(pc), .predict_req(predict_req),
        .prediction(prediction), .prediction_valid(prediction_valid), .pred_ghr(pred_ghr),
        .update_valid(update_valid), .update_pc(update_pc), .update_ghr(update_ghr),
        .update_taken(update_taken), .update_correct(update_correct),
        .perf_lookups(perf_lookups), .perf_mispredicts(perf_mispredicts)
    );

    typedef struct packed {
        logic        req;
        logic [31:0] pc;
        logic        upd;
        logic [31:0] upc;
        logic [7:0]  ughr;
        logic        utaken;
        logic        ucorrect;
        logic        exp_valid;
        logic        exp_pred;
        logic [7:0]  exp_ghr;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic drive(input vec_t v);
        predict_req    = v.req;
        pc             = v.pc;
        update_valid   = v.upd;
        update_pc      = v.upc;
        update_ghr     = v.ughr;
        update_taken   = v.utaken;
        update_correct = v.ucorrect;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        int bad_valid;
        int early_ready;
        int exp_lookups;
        int exp_mis;

        //        req  pc         upd  upc        ughr   tk   corr  vld  pred ghr
        vecs[0]  = '{1'b1, 32'h100, 1'b0, 32'h0,   8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 32'h0,   1'b0, 32'h0,   8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 32'h0,   1'b1, 32'h40,  8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 32'h0,   1'b1, 32'h40,  8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 32'h0,   1'b1, 32'h0,   8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 32'h40,  1'b0, 32'h0,   8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00};
        vecs[6]  = '{1'b0, 32'h0,   1'b1, 32'h40,  8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[7]  = '{1'b1, 32'h44,  1'b0, 32'h0,   8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01};
        vecs[8]  = '{1'b0, 32'h0,   1'b1, 32'h200, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01};
        vecs[9]  = '{1'b1, 32'h104, 1'b0, 32'h0,   8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[10] = '{1'b1, 32'h108, 1'b0, 32'h0,   8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[11] = '{1'b1, 32'h10C, 1'b0, 32'h0,   8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 32'h0,   1'b1, 32'h300, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[13] = '{1'b1, 32'h0,   1'b0, 32'h0,   8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0B};
        vecs[14] = '{1'b1, 32'h120, 1'b1, 32'h3FC, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0, 8'h16};
        vecs[15] = '{1'b1, 32'h0,   1'b0, 32'h0,   8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h40};
        vecs[16] = '{1'b1, 32'h208, 1'b1, 32'h8,   8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h80};
        vecs[17] = '{1'b1, 32'h8,   1'b0, 32'h0,   8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00};

        rst = 1'b1;
        drive('0);
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_valid", 32'(prediction_valid), 32'h0);
        check("rst_pred", 32'(prediction), 32'h0);
        check("rst_pred_ghr", 32'(pred_ghr), 32'h0);
        check("rst_perf_lookups", perf_lookups, 32'h0);

        // Requests and updates held active through the sweep must be ignored.
        predict_req = 1'b1; pc = 32'h100;
        update_valid = 1'b1; update_pc = 32'h100; update_ghr = 8'h00;
        update_taken = 1'b1; update_correct = 1'b0;
        rst = 1'b0;
        bad_valid = 0;
        early_ready = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (prediction_valid) bad_valid++;
            if (ready) early_ready++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycles = 0;
        while (!ready && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
            if (prediction_valid) bad_valid++;
        end
        check("sweep_ready_latency", 32'(cycles), 32'd256);
        check("sweep_early_ready", 32'(early_ready), 32'h0);
        check("sweep_valid_pulses", 32'(bad_valid), 32'h0);
        check("sweep_perf_lookups", perf_lookups, 32'h0);

        exp_lookups = 0;
        exp_mis = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            if (vecs[i].req) exp_lookups++;
            if (vecs[i].upd && !vecs[i].ucorrect) exp_mis++;
            @(posedge clk); #1;
            check($sformatf("v%0d_valid", i), 32'(prediction_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_pred", i), 32'(prediction), 32'(vecs[i].exp_pred));
            check($sformatf("v%0d_pred_ghr", i), 32'(pred_ghr), 32'(vecs[i].exp_ghr));
        end

`ifdef PERF_CNT_EN
        check("perf_lookups", perf_lookups, 32'(exp_lookups));
        check("perf_mispredicts", perf_mispredicts, 32'(exp_mis));
`else
        check("perf_lookups_off", perf_lookups, 32'h0);
        check("perf_mispredicts_off", perf_mispredicts, 32'h0);
`endif

        // Asynchronous reset between edges must clear outputs immediately.
        @(negedge clk);
        drive('0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_ready", 32'(ready), 32'h0);
        check("async_rst_valid", 32'(prediction_valid), 32'h0);
        check("async_rst_pred", 32'(prediction), 32'h0);
        check("async_rst_perf_mis", perf_mispredicts, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
